// File: rtl/range_window_checker.sv
// Multi-channel temporal checker: each sampled req must see an ack between MIN_DLY and
// MAX_DLY edges later. Per-channel age vectors track every overlapping pending thread.
module range_window_checker #(
    parameter int NCH     = 4,
    parameter int MIN_DLY = 2,
    parameter int MAX_DLY = 5,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en_i,
    input  logic                 clr_i,
    input  logic [NCH-1:0]       req_i,
    input  logic [NCH-1:0]       ack_i,
    output logic [NCH-1:0]       pass_o,
    output logic [NCH-1:0]       fail_o,
    output logic [NCH-1:0]       pend_o,
    output logic                 err_o,
    output logic [NCH*CNT_W-1:0] pass_cnt_o,
    output logic [NCH*CNT_W-1:0] fail_cnt_o
);

    // Wide enough to hold the number of threads one ack can resolve at once.
    localparam int HIT_W = (MAX_DLY < 1) ? 1 : $clog2(MAX_DLY + 1);
    localparam int SUM_W = CNT_W + 1;

    if (NCH < 1 || NCH > 32 || MIN_DLY < 1 || MAX_DLY < MIN_DLY || MAX_DLY > 31
        || CNT_W < HIT_W) begin : g_param_err
        $error("range_window_checker: illegal parameter combination");
    end

    logic [NCH-1:0] miss_all;
    logic           err_q;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [MAX_DLY:1] age_q;
        logic [MAX_DLY:1] age_d;
        logic [MAX_DLY:1] hit;
        logic             miss;
        logic [HIT_W-1:0] hit_cnt;
        logic [SUM_W-1:0] pass_sum;
        logic [CNT_W-1:0] pass_cnt_q;
        logic [CNT_W-1:0] fail_cnt_q;
        logic             pass_q;
        logic             fail_q;
        logic             pend_q;

        // Resolve in-window threads on ack, age the survivors, and launch a new one.
        always_comb begin
            hit     = '0;
            hit_cnt = '0;
            for (int k = MIN_DLY; k <= MAX_DLY; k++) begin
                hit[k]  = age_q[k] & ack_i[c];
                hit_cnt = hit_cnt + HIT_W'(hit[k]);
            end
            miss     = age_q[MAX_DLY] & ~ack_i[c];
            age_d    = '0;
            age_d[1] = req_i[c] & en_i;
            for (int k = 1; k < MAX_DLY; k++) begin
                age_d[k+1] = age_q[k] & ~hit[k];
            end
            pass_sum = {1'b0, pass_cnt_q} + SUM_W'(hit_cnt);
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                age_q      <= '0;
                pass_q     <= 1'b0;
                fail_q     <= 1'b0;
                pend_q     <= 1'b0;
                pass_cnt_q <= '0;
                fail_cnt_q <= '0;
            end else begin
                age_q  <= age_d;
                pass_q <= |hit;
                fail_q <= miss;
                pend_q <= |age_d;
                // Clear beats any same-edge increment; counters clamp instead of wrapping.
                if (clr_i) begin
                    pass_cnt_q <= '0;
                    fail_cnt_q <= '0;
                end else begin
                    if (pass_sum[CNT_W]) begin
                        pass_cnt_q <= '1;
                    end else begin
                        pass_cnt_q <= pass_sum[CNT_W-1:0];
                    end
                    if (miss && (fail_cnt_q != '1)) begin
                        fail_cnt_q <= fail_cnt_q + 1'b1;
                    end
                end
            end
        end

        assign miss_all[c]                   = miss;
        assign pass_o[c]                     = pass_q;
        assign fail_o[c]                     = fail_q;
        assign pend_o[c]                     = pend_q;
        assign pass_cnt_o[c*CNT_W +: CNT_W]  = pass_cnt_q;
        assign fail_cnt_o[c*CNT_W +: CNT_W]  = fail_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (clr_i) begin
            err_q <= 1'b0;
        end else if (|miss_all) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;

endmodule

// File: tb/tb_range_window_checker.sv
// Bench for range_window_checker: directed scenarios plus random traffic, checked against
// a thread-list model that tracks each launched req by its launch edge.
module tb_range_window_checker;

    localparam int NCH     = 4;
    localparam int MIN_DLY = 2;
    localparam int MAX_DLY = 5;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                 clk;
    logic                 rst_n;
    logic                 en_i;
    logic                 clr_i;
    logic [NCH-1:0]       req_i;
    logic [NCH-1:0]       ack_i;
    logic [NCH-1:0]       pass_o;
    logic [NCH-1:0]       fail_o;
    logic [NCH-1:0]       pend_o;
    logic                 err_o;
    logic [NCH*CNT_W-1:0] pass_cnt_o;
    logic [NCH*CNT_W-1:0] fail_cnt_o;

    range_window_checker #(
        .NCH(NCH), .MIN_DLY(MIN_DLY), .MAX_DLY(MAX_DLY), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en_i(en_i), .clr_i(clr_i),
        .req_i(req_i), .ack_i(ack_i),
        .pass_o(pass_o), .fail_o(fail_o), .pend_o(pend_o), .err_o(err_o),
        .pass_cnt_o(pass_cnt_o), .fail_cnt_o(fail_cnt_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int ch;
        int launch;
    } thr_t;

    thr_t           thr_q[$];
    int             edge_n;
    int             m_pcnt[NCH];
    int             m_fcnt[NCH];
    logic           m_err;
    logic [NCH-1:0] m_pass;
    logic [NCH-1:0] m_fail;
    logic [NCH-1:0] m_pend;
    int             checks;
    int             errors;

    task automatic modelReset();
        thr_q.delete();
        for (int c = 0; c < NCH; c++) begin
            m_pcnt[c] = 0;
            m_fcnt[c] = 0;
        end
        m_err  = 1'b0;
        m_pass = '0;
        m_fail = '0;
        m_pend = '0;
    endtask

    // One clock edge of the property: each thread is judged by its age in edges.
    task automatic modelEdge(input logic [NCH-1:0] r, input logic [NCH-1:0] a,
                             input logic e, input logic cl);
        thr_t keep[$];
        int   pinc[NCH];
        int   age;
        for (int c = 0; c < NCH; c++) pinc[c] = 0;
        m_pass = '0;
        m_fail = '0;
        foreach (thr_q[i]) begin
            age = edge_n - thr_q[i].launch;
            if (a[thr_q[i].ch] && age >= MIN_DLY && age <= MAX_DLY) begin
                m_pass[thr_q[i].ch] = 1'b1;
                pinc[thr_q[i].ch]++;
            end else if (age >= MAX_DLY) begin
                m_fail[thr_q[i].ch] = 1'b1;
            end else begin
                keep.push_back(thr_q[i]);
            end
        end
        thr_q = keep;
        for (int c = 0; c < NCH; c++) begin
            if (r[c] && e) thr_q.push_back('{ch: c, launch: edge_n});
        end
        if (cl) begin
            for (int c = 0; c < NCH; c++) begin
                m_pcnt[c] = 0;
                m_fcnt[c] = 0;
            end
            m_err = 1'b0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                m_pcnt[c] = (m_pcnt[c] + pinc[c] > CNT_MAX) ? CNT_MAX : m_pcnt[c] + pinc[c];
                if (m_fail[c] && m_fcnt[c] < CNT_MAX) m_fcnt[c]++;
            end
            if (|m_fail) m_err = 1'b1;
        end
        m_pend = '0;
        foreach (thr_q[i]) m_pend[thr_q[i].ch] = 1'b1;
        edge_n++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        logic [NCH*CNT_W-1:0] exp_pc;
        logic [NCH*CNT_W-1:0] exp_fc;
        for (int c = 0; c < NCH; c++) begin
            exp_pc[c*CNT_W +: CNT_W] = CNT_W'(m_pcnt[c]);
            exp_fc[c*CNT_W +: CNT_W] = CNT_W'(m_fcnt[c]);
        end
        check("pass_o", 32'(pass_o), 32'(m_pass));
        check("fail_o", 32'(fail_o), 32'(m_fail));
        check("pend_o", 32'(pend_o), 32'(m_pend));
        check("err_o", 32'(err_o), 32'(m_err));
        check("pass_cnt", 32'(pass_cnt_o), 32'(exp_pc));
        check("fail_cnt", 32'(fail_cnt_o), 32'(exp_fc));
        check("pass_fail_excl", 32'(pass_o & fail_o), 32'd0);
    endtask

    task automatic applyStimulus(input logic [NCH-1:0] r, input logic [NCH-1:0] a,
                                 input logic e, input logic cl);
        req_i = r;
        ack_i = a;
        en_i  = e;
        clr_i = cl;
        @(posedge clk);
        modelEdge(r, a, e, cl);
        #1;
        checkOutput();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus('0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        edge_n = 0;
        rst_n  = 1'b0;
        en_i   = 1'b0;
        clr_i  = 1'b0;
        req_i  = '0;
        ack_i  = '0;
        modelReset();
        #2;
        checkOutput();
        #10 rst_n = 1'b1;

        // T1: ack two edges after req passes.
        applyStimulus('0, '0, 1'b1, 1'b1);
        applyStimulus(4'b0001, '0, 1'b1, 1'b0);
        applyStimulus('0, '0, 1'b1, 1'b0);
        applyStimulus('0, 4'b0001, 1'b1, 1'b0);
        check("t1_pass", 32'(pass_o[0]), 32'd1);
        check("t1_pcnt", 32'(pass_cnt_o[CNT_W-1:0]), 32'd1);
        check("t1_pend", 32'(pend_o[0]), 32'd0);
        idle(6);

        // T2: early ack is ignored, thread fails when the window closes.
        applyStimulus('0, '0, 1'b1, 1'b1);
        applyStimulus(4'b0001, '0, 1'b1, 1'b0);
        applyStimulus('0, 4'b0001, 1'b1, 1'b0);
        idle(3);
        check("t2_nofail_yet", 32'(fail_o[0]), 32'd0);
        idle(1);
        check("t2_fail", 32'(fail_o[0]), 32'd1);
        check("t2_fcnt", 32'(fail_cnt_o[CNT_W-1:0]), 32'd1);
        idle(2);
        check("t2_err_held", 32'(err_o), 32'd1);

        // T3: one ack resolves three overlapping threads; a late ack does nothing.
        applyStimulus('0, '0, 1'b1, 1'b1);
        applyStimulus(4'b0001, '0, 1'b1, 1'b0);
        applyStimulus(4'b0001, '0, 1'b1, 1'b0);
        applyStimulus(4'b0001, '0, 1'b1, 1'b0);
        applyStimulus('0, '0, 1'b1, 1'b0);
        applyStimulus('0, 4'b0001, 1'b1, 1'b0);
        check("t3_pcnt", 32'(pass_cnt_o[CNT_W-1:0]), 32'd3);
        applyStimulus(4'b0001, '0, 1'b1, 1'b0);
        idle(5);
        check("t3_late_fail", 32'(fail_o[0]), 32'd1);
        applyStimulus('0, 4'b0001, 1'b1, 1'b0);
        check("t3_pcnt_kept", 32'(pass_cnt_o[CNT_W-1:0]), 32'd3);
        idle(6);

        // T4: independent channels.
        applyStimulus('0, '0, 1'b1, 1'b1);
        applyStimulus(4'b0101, '0, 1'b1, 1'b0);
        idle(2);
        applyStimulus('0, 4'b0001, 1'b1, 1'b0);
        check("t4_ch0_pass", 32'(pass_o), 32'b0001);
        idle(2);
        check("t4_ch2_fail", 32'(fail_o), 32'b0100);
        check("t4_ch1_ch3_zero", 32'({pass_cnt_o[15:12], pass_cnt_o[7:4],
                                     fail_cnt_o[15:12], fail_cnt_o[7:4]}), 32'd0);
        idle(6);

        // T5: asynchronous reset drops pending threads silently.
        applyStimulus(4'b0001, '0, 1'b1, 1'b0);
        idle(3);
        #3 rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput();
        #1 rst_n = 1'b1;
        idle(7);

        // T6: saturation, clear beating a pass, and disabled launches.
        applyStimulus(4'b0001, '0, 1'b1, 1'b0);
        idle(5);
        check("t6_err_set", 32'(err_o), 32'd1);
        for (int i = 0; i < 17; i++) begin
            applyStimulus(4'b0001, '0, 1'b1, 1'b0);
            applyStimulus('0, '0, 1'b1, 1'b0);
            applyStimulus('0, 4'b0001, 1'b1, 1'b0);
        end
        check("t6_sat", 32'(pass_cnt_o[CNT_W-1:0]), 32'd15);
        applyStimulus(4'b0001, '0, 1'b1, 1'b0);
        applyStimulus('0, '0, 1'b1, 1'b0);
        applyStimulus('0, 4'b0001, 1'b1, 1'b1);
        check("t6_clr_pass", 32'(pass_o[0]), 32'd1);
        check("t6_clr_cnt", 32'(pass_cnt_o[CNT_W-1:0]), 32'd0);
        check("t6_clr_err", 32'(err_o), 32'd0);
        applyStimulus(4'b1111, '0, 1'b0, 1'b0);
        check("t6_en_off", 32'(pend_o), 32'd0);
        idle(6);

        // Random traffic against the thread model.
        for (int i = 0; i < 600; i++) begin
            applyStimulus(NCH'($urandom), NCH'($urandom),
                          1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 39) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
